cpu_writeback: RTL and testbench

CPU_WRITEBACK -- requirements
Module: cpu_writeback

---
 rtl/cpu_writeback.sv | 168 ++++++++++++++++
 tb/tb_cpu_writeback.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_writeback.sv
// cpu_writeback: retirement stage of the CPU pipeline.
//
// A memory-stage record {tag, inst_rd, rd} arrives on i_data. A record is new
// whenever its tag differs from the tag of the last record taken (o_tag). An
// IDLE cycle takes a new record and moves to WRITE. WRITE lasts exactly one
// cycle: it raises the register-file strobe (unless rd is x0), and at the edge
// that closes the cycle it updates the two-deep forwarding history and the
// retired-instruction counter. i_stall parks the FSM in HALT, where nothing is
// taken.
//
// Ports
//   i_clock       clock, rising edge
//   i_reset       synchronous active-high reset
//   i_stall       debug halt, blocks consumption of new records
//   i_data        memory-stage record (memory_data_t)
//   o_busy        a record is pending or being committed
//   o_rf_write    register-file write strobe
//   o_rf_index    register-file write index
//   o_rf_wdata    register-file write data
//   o_fwd0_*      most recent committed register write
//   o_fwd1_*      second most recent committed register write
//   o_retired     count of committed records, wraps silently
//   o_tag         tag of the last consumed record

package cpu_writeback_pkg;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [4:0]       inst_rd;
    logic [31:0]      rd;
  } memory_data_t;
endpackage

module cpu_writeback
  import cpu_writeback_pkg::*;
#(
  parameter int RETIRE_WIDTH = 64
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_stall,
  input  memory_data_t            i_data,
  output logic                    o_busy,
  output logic                    o_rf_write,
  output logic [4:0]              o_rf_index,
  output logic [31:0]             o_rf_wdata,
  output logic                    o_fwd0_valid,
  output logic [4:0]              o_fwd0_index,
  output logic [31:0]             o_fwd0_value,
  output logic                    o_fwd1_valid,
  output logic [4:0]              o_fwd1_index,
  output logic [31:0]             o_fwd1_value,
  output logic [RETIRE_WIDTH-1:0] o_retired,
  output logic [TAG_W-1:0]        o_tag
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [TAG_W-1:0]        tag_q;
  logic [4:0]              idx_q;
  logic [31:0]             data_q;
  logic                    fwd0_vld_q, fwd1_vld_q;
  logic [4:0]              fwd0_idx_q, fwd1_idx_q;
  logic [31:0]             fwd0_val_q, fwd1_val_q;
  logic [RETIRE_WIDTH-1:0] retired_q;

  logic new_rec;
  logic consume;
  logic in_write;

  assign new_rec  = (i_data.tag != tag_q);
  assign consume  = (state_q == IDLE) && !i_stall && new_rec;
  assign in_write = (state_q == WRITE);

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A stall seen during WRITE lets the write finish and
  // parks in HALT afterwards; a tag change seen during WRITE stays visible on
  // i_data and is picked up by the following IDLE cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (i_stall) begin
          state_d = HALT;
        end else if (new_rec) begin
          state_d = WRITE;
        end
      end
      WRITE:   state_d = i_stall ? HALT : IDLE;
      HALT:    if (!i_stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic. The strobe is gated by i_reset so that a reset landing on
  // the WRITE cycle suppresses the write in that same cycle.
  always_comb begin
    o_busy     = new_rec;
    o_rf_write = 1'b0;
    if (state_q == WRITE) begin
      o_busy     = 1'b1;
      o_rf_write = (idx_q != 5'd0) && !i_reset;
    end
  end

  // Record latch, forwarding history and retire counter. All commit side
  // effects happen at the edge that closes the WRITE cycle, so a reset in that
  // cycle discards the record entirely.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      tag_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      fwd0_vld_q <= 1'b0;
      fwd0_idx_q <= '0;
      fwd0_val_q <= '0;
      fwd1_vld_q <= 1'b0;
      fwd1_idx_q <= '0;
      fwd1_val_q <= '0;
      retired_q  <= '0;
    end else begin
      if (consume) begin
        tag_q  <= i_data.tag;
        idx_q  <= i_data.inst_rd;
        data_q <= i_data.rd;
      end
      if (in_write) begin
        retired_q <= retired_q + RETIRE_WIDTH'(1);
        // Writes to x0 are architecturally invisible, so they never enter the
        // forwarding history. Repeated indices are shifted in without dedup.
        if (idx_q != 5'd0) begin
          fwd1_vld_q <= fwd0_vld_q;
          fwd1_idx_q <= fwd0_idx_q;
          fwd1_val_q <= fwd0_val_q;
          fwd0_vld_q <= 1'b1;
          fwd0_idx_q <= idx_q;
          fwd0_val_q <= data_q;
        end
      end
    end
  end

  assign o_rf_index   = idx_q;
  assign o_rf_wdata   = data_q;
  assign o_fwd0_valid = fwd0_vld_q;
  assign o_fwd0_index = fwd0_idx_q;
  assign o_fwd0_value = fwd0_val_q;
  assign o_fwd1_valid = fwd1_vld_q;
  assign o_fwd1_index = fwd1_idx_q;
  assign o_fwd1_value = fwd1_val_q;
  assign o_retired    = retired_q;
  assign o_tag        = tag_q;

endmodule

// File: tb/tb_cpu_writeback.sv
module tb_cpu_writeback;
  import cpu_writeback_pkg::*;

  logic         i_clock = 1'b0;
  logic         i_reset;
  logic         i_stall;
  memory_data_t i_data;
  logic         o_busy, o_rf_write;
  logic [4:0]   o_rf_index;
  logic [31:0]  o_rf_wdata;
  logic         o_fwd0_valid, o_fwd1_valid;
  logic [4:0]   o_fwd0_index, o_fwd1_index;
  logic [31:0]  o_fwd0_value, o_fwd1_value;
  logic [63:0]  o_retired;
  logic [3:0]   o_tag;

  cpu_writeback #(.RETIRE_WIDTH(64)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_stall(i_stall), .i_data(i_data),
    .o_busy(o_busy), .o_rf_write(o_rf_write), .o_rf_index(o_rf_index),
    .o_rf_wdata(o_rf_wdata),
    .o_fwd0_valid(o_fwd0_valid), .o_fwd0_index(o_fwd0_index), .o_fwd0_value(o_fwd0_value),
    .o_fwd1_valid(o_fwd1_valid), .o_fwd1_index(o_fwd1_index), .o_fwd1_value(o_fwd1_value),
    .o_retired(o_retired), .o_tag(o_tag)
  );

  always #5 i_clock = ~i_clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: architectural view of the writeback stage.
  typedef struct { logic [4:0] idx; logic [31:0] val; } wr_t;
  wr_t         m_hist[$];      // committed register writes, newest first
  logic [3:0]  m_tag;
  logic [4:0]  m_idx;
  logic [31:0] m_val;
  logic        m_pending;      // a taken record is being committed this cycle
  logic        m_halted;
  logic [63:0] m_retired;
  logic        m_valid = 1'b0;

  task automatic model_update(input logic rst, input logic stall, input memory_data_t d);
    if (rst) begin
      m_hist.delete();
      m_tag = '0; m_idx = '0; m_val = '0;
      m_pending = 1'b0; m_halted = 1'b0; m_retired = '0;
      m_valid = 1'b1;
    end else if (m_pending) begin
      m_retired = m_retired + 64'd1;
      if (m_idx != 5'd0) begin
        m_hist.push_front('{idx: m_idx, val: m_val});
        if (m_hist.size() > 2) void'(m_hist.pop_back());
      end
      m_pending = 1'b0;
      m_halted  = stall;
    end else if (m_halted) begin
      m_halted = stall;
    end else if (stall) begin
      m_halted = 1'b1;
    end else if (d.tag != m_tag) begin
      m_tag = d.tag; m_idx = d.inst_rd; m_val = d.rd;
      m_pending = 1'b1;
    end
  endtask

  task automatic compare_all();
    chk("rf_write", o_rf_write, m_pending && (m_idx != 0) && !i_reset);
    chk("rf_index", o_rf_index, m_idx);
    chk("rf_wdata", o_rf_wdata, m_val);
    chk("busy",     o_busy, (i_data.tag != m_tag) || m_pending);
    chk("fwd0_valid", o_fwd0_valid, m_hist.size() > 0);
    chk("fwd0_index", o_fwd0_index, m_hist.size() > 0 ? m_hist[0].idx : 5'd0);
    chk("fwd0_value", o_fwd0_value, m_hist.size() > 0 ? m_hist[0].val : 32'd0);
    chk("fwd1_valid", o_fwd1_valid, m_hist.size() > 1);
    chk("fwd1_index", o_fwd1_index, m_hist.size() > 1 ? m_hist[1].idx : 5'd0);
    chk("fwd1_value", o_fwd1_value, m_hist.size() > 1 ? m_hist[1].val : 32'd0);
    chk("retired",  o_retired, m_retired);
    chk("tag",      o_tag, m_tag);
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
  task automatic step(input logic rst, input logic stall, input logic [3:0] tg,
                      input logic [4:0] rdi, input logic [31:0] val);
    memory_data_t d;
    d = {tg, rdi, val};
    i_reset = rst; i_stall = stall; i_data = d;
    #1;
    if (m_valid) compare_all();
    @(posedge i_clock);
    model_update(rst, stall, d);
    @(negedge i_clock);
  endtask

  int strobes;
  logic [3:0] cur_tag;

  initial begin
    i_reset = 1'b1; i_stall = 1'b0; i_data = '0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    #1;
    chk("reset_retired", o_retired, 64'd0);
    chk("reset_fwd0", o_fwd0_valid, 1'b0);
    chk("reset_busy", o_busy, 1'b0);

    // First record commits one cycle after it is taken
    step(0, 0, 1, 5, 32'hDEADBEEF);
    chk("v1_strobe", o_rf_write, 1'b1);
    chk("v1_index", o_rf_index, 5'd5);
    chk("v1_data", o_rf_wdata, 32'hDEADBEEF);
    chk("v1_tag", o_tag, 4'd1);
    step(0, 0, 1, 5, 32'hDEADBEEF);
    chk("v1_fwd0", {o_fwd0_valid, o_fwd0_index, o_fwd0_value}, {1'b1, 5'd5, 32'hDEADBEEF});
    chk("v1_retired", o_retired, 64'd1);

    // Record to x0: counted, not written, history untouched
    step(0, 0, 2, 0, 32'h12345678);
    chk("x0_strobe", o_rf_write, 1'b0);
    step(0, 0, 2, 0, 32'h12345678);
    chk("x0_fwd0", o_fwd0_index, 5'd5);
    chk("x0_retired", o_retired, 64'd2);

    // Back-to-back x3 then x4; second tag arrives during the first WRITE
    step(0, 0, 3, 3, 32'h11);
    step(0, 0, 4, 4, 32'h22);
    chk("b2b_busy_pending", o_busy, 1'b1);
    step(0, 0, 4, 4, 32'h22);
    chk("b2b_busy_write", o_busy, 1'b1);
    step(0, 0, 4, 4, 32'h22);
    chk("b2b_busy_done", o_busy, 1'b0);
    chk("b2b_fwd0", {o_fwd0_valid, o_fwd0_index, o_fwd0_value}, {1'b1, 5'd4, 32'h22});
    chk("b2b_fwd1", {o_fwd1_valid, o_fwd1_index, o_fwd1_value}, {1'b1, 5'd3, 32'h11});

    // Stall with a pending record: nothing consumed for 10 cycles
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 5, 6, 32'h66);
      strobes += int'(o_rf_write);
    end
    chk("stall_strobes", strobes, 0);
    chk("stall_busy", o_busy, 1'b1);
    chk("stall_tag", o_tag, 4'd4);
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 5, 6, 32'h66);
      strobes += int'(o_rf_write);
    end
    chk("release_strobes", strobes, 1);
    chk("release_retired", o_retired, 64'd5);

    // Reset landing on the WRITE cycle
    step(0, 0, 6, 7, 32'hAA);
    step(1, 0, 6, 7, 32'hAA);
    chk("rstw_retired", o_retired, 64'd0);
    chk("rstw_fwd0", o_fwd0_valid, 1'b0);
    chk("rstw_index", o_rf_index, 5'd0);
    chk("rstw_tag", o_tag, 4'd0);

    // Counter wrap
    force dut.retired_q = '1;
    #1;
    release dut.retired_q;
    m_retired = '1;
    step(0, 0, 6, 7, 32'hAA);
    step(0, 0, 6, 7, 32'hAA);
    chk("wrap_zero", o_retired, 64'd0);
    step(0, 0, 7, 8, 32'hBB);
    step(0, 0, 7, 8, 32'hBB);
    chk("wrap_one", o_retired, 64'd1);

    // Randomized traffic
    cur_tag = 4'd7;
    for (int i = 0; i < 600; i++) begin
      logic r, s;
      logic [4:0] ri;
      r = ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 1) == 1) cur_tag = cur_tag + 4'($urandom_range(1, 15));
      ri = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step(r, s, cur_tag, ri, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
